// File: rtl/qspi_xfer_seq.sv
// QSPI transfer sequencer: steps CMD/ADDR/DUMMY/DATA phases on SCLK ticks and drives datapath strobes and lane selects.
// Latency: one load cycle after start, then 8 + addr + dummy + beats*beat_len ticks, then one DONE cycle; outputs registered.
// Backpressure: none; progress is paced solely by tick_in, abort_in or h_rst drop the transfer back to IDLE.
module qspi_xfer_seq #(
    parameter int DUMMY_CYCLES = 6
) (
    input  logic       h_clk,
    input  logic       h_rst,
    input  logic       tick_in,
    input  logic       start_in,
    input  logic       wr_in,
    input  logic [1:0] lanes_in,
    input  logic       addr_4b_in,
    input  logic [4:0] beats_in,
    input  logic       abort_in,
    output logic       busy_out,
    output logic       done_out,
    output logic       err_out,
    output logic       cs_n_out,
    output logic       gen_sclk_out,
    output logic       load_cmd_out,
    output logic       cmd_shift_en_out,
    output logic       load_addr_out,
    output logic       addr_shift_en_out,
    output logic       load_shift_data_out,
    output logic       data_shift_en_out,
    output logic       data_sample_en_out,
    output logic       rd_push_out,
    output logic       wr_pop_out,
    output logic [2:0] io0_sel_out,
    output logic [1:0] io1_sel_out,
    output logic [1:0] io2_sel_out,
    output logic [1:0] io3_sel_out
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DONE
    } state_t;

    localparam logic [5:0] DUMMY_LEN = 6'(DUMMY_CYCLES);

    state_t     state_q, state_d;
    logic       pend_q, pend_d;
    logic       wr_q, wr_d;
    logic [1:0] lanes_q, lanes_d;
    logic       a4_q, a4_d;
    logic [4:0] beats_q, beats_d;
    logic [5:0] tick_cnt_q, tick_cnt_d;
    logic [4:0] beat_cnt_q, beat_cnt_d;

    logic       busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic       cs_n_q, cs_n_d, sclk_q, sclk_d;
    logic       ld_cmd_q, ld_cmd_d, cmd_sh_q, cmd_sh_d;
    logic       ld_addr_q, ld_addr_d, addr_sh_q, addr_sh_d;
    logic       ld_sd_q, ld_sd_d, data_sh_q, data_sh_d, data_smp_q, data_smp_d;
    logic       rd_push_q, rd_push_d, wr_pop_q, wr_pop_d;
    logic [2:0] io0_q, io0_d;
    logic [1:0] io1_q, io1_d, io2_q, io2_d, io3_q, io3_d;

    logic [5:0] addr_len, beat_len, phase_len;
    logic       phase_end, last_beat, in_phase, active_d;
    logic [1:0] lane_code;

    // Lane count divides the bit count: lanes code 0/1/2 is a shift of 0/1/2.
    assign addr_len  = (a4_q ? 6'd32 : 6'd24) >> lanes_q;
    assign beat_len  = 6'd32 >> lanes_q;
    assign last_beat = (beat_cnt_q == beats_q - 5'd1);
    assign in_phase  = (state_q == S_CMD) || (state_q == S_ADDR) ||
                       (state_q == S_DUMMY) || (state_q == S_DATA);

    always_comb begin
        case (state_q)
            S_CMD:   phase_len = 6'd8;
            S_ADDR:  phase_len = addr_len;
            S_DUMMY: phase_len = DUMMY_LEN;
            S_DATA:  phase_len = beat_len;
            default: phase_len = 6'd1;
        endcase
    end

    assign phase_end = tick_in && in_phase && (tick_cnt_q == phase_len - 6'd1);

    always_comb begin
        state_d    = state_q;
        pend_d     = 1'b0;
        wr_d       = wr_q;
        lanes_d    = lanes_q;
        a4_d       = a4_q;
        beats_d    = beats_q;
        tick_cnt_d = tick_cnt_q;
        beat_cnt_d = beat_cnt_q;
        ld_cmd_d   = 1'b0;
        ld_addr_d  = 1'b0;
        ld_sd_d    = 1'b0;
        wr_pop_d   = 1'b0;
        rd_push_d  = 1'b0;
        err_d      = 1'b0;
        done_d     = 1'b0;

        if (tick_in && in_phase) begin
            tick_cnt_d = phase_end ? 6'd0 : tick_cnt_q + 6'd1;
        end

        case (state_q)
            S_IDLE: begin
                // pend_q marks the single load cycle between start and CMD.
                if (pend_q) begin
                    state_d    = S_CMD;
                    tick_cnt_d = 6'd0;
                    beat_cnt_d = 5'd0;
                end else if (start_in) begin
                    if (lanes_in == 2'b11) begin
                        err_d = 1'b1;
                    end else begin
                        wr_d      = wr_in;
                        lanes_d   = lanes_in;
                        a4_d      = addr_4b_in;
                        beats_d   = (beats_in == 5'd0) ? 5'd1 :
                                    (beats_in > 5'd16) ? 5'd16 : beats_in;
                        pend_d    = 1'b1;
                        ld_cmd_d  = 1'b1;
                        ld_addr_d = 1'b1;
                    end
                end
            end
            S_CMD: begin
                if (phase_end) state_d = S_ADDR;
            end
            S_ADDR: begin
                if (phase_end) begin
                    if (wr_q || (lanes_q == 2'b00) || (DUMMY_LEN == 6'd0)) begin
                        state_d    = S_DATA;
                        beat_cnt_d = 5'd0;
                        ld_sd_d    = wr_q;
                        wr_pop_d   = wr_q;
                    end else begin
                        state_d = S_DUMMY;
                    end
                end
            end
            S_DUMMY: begin
                if (phase_end) begin
                    state_d    = S_DATA;
                    beat_cnt_d = 5'd0;
                end
            end
            S_DATA: begin
                if (phase_end) begin
                    rd_push_d = !wr_q;
                    if (last_beat) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 5'd1;
                        ld_sd_d    = wr_q;
                        wr_pop_d   = wr_q;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort beats any same-cycle phase completion, so no late push/pop/done escapes.
        if (abort_in && ((state_q != S_IDLE) || pend_q)) begin
            state_d    = S_IDLE;
            pend_d     = 1'b0;
            tick_cnt_d = 6'd0;
            beat_cnt_d = 5'd0;
            ld_cmd_d   = 1'b0;
            ld_addr_d  = 1'b0;
            ld_sd_d    = 1'b0;
            wr_pop_d   = 1'b0;
            rd_push_d  = 1'b0;
            err_d      = 1'b0;
            done_d     = 1'b0;
        end
    end

    always_comb begin
        active_d   = (state_d == S_CMD) || (state_d == S_ADDR) ||
                     (state_d == S_DUMMY) || (state_d == S_DATA);
        cs_n_d     = !active_d;
        sclk_d     = active_d;
        busy_d     = active_d || pend_d;
        cmd_sh_d   = (state_d == S_CMD);
        addr_sh_d  = (state_d == S_ADDR);
        data_sh_d  = (state_d == S_DATA) && wr_q;
        data_smp_d = (state_d == S_DATA) && !wr_q;
        lane_code  = 2'b00;
        io0_d      = 3'b000;
        io1_d      = 2'b00;
        io2_d      = 2'b00;
        io3_d      = 2'b00;
        case (state_d)
            S_CMD:  io0_d = 3'b010;
            S_ADDR: begin
                io0_d     = 3'b011;
                lane_code = 2'b01;
            end
            S_DATA: begin
                io0_d     = wr_q ? 3'b101 : 3'b100;
                lane_code = wr_q ? 2'b11 : 2'b10;
            end
            default: io0_d = 3'b000;
        endcase
        if (lanes_q != 2'b00) io1_d = lane_code;
        if (lanes_q[1]) begin
            io2_d = lane_code;
            io3_d = lane_code;
        end
    end

    always_ff @(posedge h_clk) begin
        if (h_rst) begin
            state_q    <= S_IDLE;
            pend_q     <= 1'b0;
            wr_q       <= 1'b0;
            lanes_q    <= 2'b00;
            a4_q       <= 1'b0;
            beats_q    <= 5'd0;
            tick_cnt_q <= 6'd0;
            beat_cnt_q <= 5'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b0;
            ld_cmd_q   <= 1'b0;
            cmd_sh_q   <= 1'b0;
            ld_addr_q  <= 1'b0;
            addr_sh_q  <= 1'b0;
            ld_sd_q    <= 1'b0;
            data_sh_q  <= 1'b0;
            data_smp_q <= 1'b0;
            rd_push_q  <= 1'b0;
            wr_pop_q   <= 1'b0;
            io0_q      <= 3'b000;
            io1_q      <= 2'b00;
            io2_q      <= 2'b00;
            io3_q      <= 2'b00;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            wr_q       <= wr_d;
            lanes_q    <= lanes_d;
            a4_q       <= a4_d;
            beats_q    <= beats_d;
            tick_cnt_q <= tick_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cs_n_q     <= cs_n_d;
            sclk_q     <= sclk_d;
            ld_cmd_q   <= ld_cmd_d;
            cmd_sh_q   <= cmd_sh_d;
            ld_addr_q  <= ld_addr_d;
            addr_sh_q  <= addr_sh_d;
            ld_sd_q    <= ld_sd_d;
            data_sh_q  <= data_sh_d;
            data_smp_q <= data_smp_d;
            rd_push_q  <= rd_push_d;
            wr_pop_q   <= wr_pop_d;
            io0_q      <= io0_d;
            io1_q      <= io1_d;
            io2_q      <= io2_d;
            io3_q      <= io3_d;
        end
    end

    assign busy_out            = busy_q;
    assign done_out            = done_q;
    assign err_out             = err_q;
    assign cs_n_out            = cs_n_q;
    assign gen_sclk_out        = sclk_q;
    assign load_cmd_out        = ld_cmd_q;
    assign cmd_shift_en_out    = cmd_sh_q;
    assign load_addr_out       = ld_addr_q;
    assign addr_shift_en_out   = addr_sh_q;
    assign load_shift_data_out = ld_sd_q;
    assign data_shift_en_out   = data_sh_q;
    assign data_sample_en_out  = data_smp_q;
    assign rd_push_out         = rd_push_q;
    assign wr_pop_out          = wr_pop_q;
    assign io0_sel_out         = io0_q;
    assign io1_sel_out         = io1_q;
    assign io2_sel_out         = io2_q;
    assign io3_sel_out         = io3_q;

endmodule

// File: tb/tb_qspi_xfer_seq.sv
// Bench for qspi_xfer_seq: each transfer's expected phase tick counts, strobes and latency are queued at start
// and compared against what the outputs show once the transfer finishes, aborts or is reset.
module tb_qspi_xfer_seq;

    localparam int DUMMY  = 6;
    localparam int BUDGET = 5000;
    localparam logic [22:0] RST_VEC = 23'd1 << 19;

    logic       h_clk = 1'b0;
    logic       h_rst, tick_in, start_in, wr_in, addr_4b_in, abort_in;
    logic [1:0] lanes_in;
    logic [4:0] beats_in;
    logic       busy_out, done_out, err_out, cs_n_out, gen_sclk_out;
    logic       load_cmd_out, cmd_shift_en_out, load_addr_out, addr_shift_en_out;
    logic       load_shift_data_out, data_shift_en_out, data_sample_en_out;
    logic       rd_push_out, wr_pop_out;
    logic [2:0] io0_sel_out;
    logic [1:0] io1_sel_out, io2_sel_out, io3_sel_out;
    logic [22:0] ovec;

    typedef struct {
        int cmd; int addr; int dum; int dat; int push; int pop; int lsd;
        int ldc; int err; int done; int lat; int bad;
    } res_t;

    res_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 h_clk = ~h_clk;

    qspi_xfer_seq #(.DUMMY_CYCLES(DUMMY)) dut (
        .h_clk(h_clk), .h_rst(h_rst), .tick_in(tick_in), .start_in(start_in),
        .wr_in(wr_in), .lanes_in(lanes_in), .addr_4b_in(addr_4b_in),
        .beats_in(beats_in), .abort_in(abort_in),
        .busy_out(busy_out), .done_out(done_out), .err_out(err_out),
        .cs_n_out(cs_n_out), .gen_sclk_out(gen_sclk_out),
        .load_cmd_out(load_cmd_out), .cmd_shift_en_out(cmd_shift_en_out),
        .load_addr_out(load_addr_out), .addr_shift_en_out(addr_shift_en_out),
        .load_shift_data_out(load_shift_data_out), .data_shift_en_out(data_shift_en_out),
        .data_sample_en_out(data_sample_en_out), .rd_push_out(rd_push_out),
        .wr_pop_out(wr_pop_out), .io0_sel_out(io0_sel_out), .io1_sel_out(io1_sel_out),
        .io2_sel_out(io2_sel_out), .io3_sel_out(io3_sel_out)
    );

    assign ovec = {busy_out, done_out, err_out, cs_n_out, gen_sclk_out,
                   load_cmd_out, cmd_shift_en_out, load_addr_out, addr_shift_en_out,
                   load_shift_data_out, data_shift_en_out, data_sample_en_out,
                   rd_push_out, wr_pop_out, io0_sel_out, io1_sel_out, io2_sel_out, io3_sel_out};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: phase lengths from lane/width rules; latency counts ticks from the first CMD cycle (offset 2).
    function automatic res_t model(input bit wr, input bit [1:0] lanes, input bit a4,
                                   input int beats, input int div);
        res_t e;
        int be, total, cnt, k;
        be     = (beats == 0) ? 1 : ((beats > 16) ? 16 : beats);
        e.cmd  = 8;
        e.addr = (a4 ? 32 : 24) >> lanes;
        e.dum  = (!wr && lanes != 2'b00) ? DUMMY : 0;
        e.dat  = be * (32 >> lanes);
        e.push = wr ? 0 : be;
        e.pop  = wr ? be : 0;
        e.lsd  = e.pop;
        e.ldc  = 1;
        e.err  = 0;
        e.done = 1;
        e.bad  = 0;
        total  = e.cmd + e.addr + e.dum + e.dat;
        cnt    = 0;
        k      = 2;
        e.lat  = -1;
        while (e.lat < 0 && k < BUDGET) begin
            if ((k % div) == div - 1) cnt++;
            if (cnt == total) e.lat = k + 1;
            k++;
        end
        return e;
    endfunction

    task automatic run_xfer(input bit wr, input bit [1:0] lanes, input bit a4, input int beats,
                            input int div, input int abort_push, input bit rst_addr,
                            input int restart_k);
        res_t e, o;
        int k, k_end, k_evt, k_push;
        logic [2:0] x0;
        logic [1:0] xl;
        e = model(wr, lanes, a4, beats, div);
        if (abort_push >= 0 || rst_addr) begin
            e.addr = -1; e.dum = -1; e.dat = -1; e.lat = -1; e.lsd = -1;
            e.done = 0;
            e.push = (abort_push >= 0) ? abort_push : 0;
            if (rst_addr) e.cmd = 8; else e.cmd = -1;
        end
        exp_q.push_back(e);
        o = '{default: 0};
        k = 0; k_end = -1; k_evt = -1; k_push = -1;
        while (k < BUDGET && (k_end < 0 || k <= k_end)) begin
            tick_in    = ((k % div) == div - 1);
            start_in   = (k == 0) || (k == restart_k);
            lanes_in   = (k == restart_k) ? 2'b11 : lanes;
            wr_in      = (k == restart_k) ? !wr : wr;
            addr_4b_in = a4;
            beats_in   = 5'(beats);
            abort_in   = 1'b0;
            h_rst      = 1'b0;
            if (abort_push >= 0 && k_push >= 0 && k == k_push + 3) begin
                abort_in = 1'b1; k_evt = k; k_end = k + 10;
            end
            if (rst_addr && k_evt < 0 && o.addr >= 5) begin
                h_rst = 1'b1; k_evt = k; k_end = k + 10;
            end
            @(negedge h_clk);
            if (tick_in && cmd_shift_en_out)  o.cmd++;
            if (tick_in && addr_shift_en_out) o.addr++;
            if (tick_in && !cs_n_out && io0_sel_out == 3'b000) o.dum++;
            if (tick_in && (data_shift_en_out || data_sample_en_out)) o.dat++;
            if (rd_push_out) begin
                o.push++;
                if (o.push == abort_push) k_push = k;
            end
            if (wr_pop_out) o.pop++;
            if (load_shift_data_out) o.lsd++;
            if (load_cmd_out && load_addr_out) o.ldc++;
            if (err_out) o.err++;
            if (done_out) begin
                o.done++;
                if (k_end < 0) begin o.lat = k; k_end = k + 3; end
            end
            xl = 2'b01;
            x0 = 3'b011;
            if (data_shift_en_out || data_sample_en_out) begin
                x0 = wr ? 3'b101 : 3'b100;
                xl = wr ? 2'b11 : 2'b10;
            end
            if (addr_shift_en_out || data_shift_en_out || data_sample_en_out) begin
                if (io0_sel_out != x0 ||
                    io1_sel_out != ((lanes != 2'b00) ? xl : 2'b00) ||
                    io2_sel_out != (lanes[1] ? xl : 2'b00) ||
                    io3_sel_out != (lanes[1] ? xl : 2'b00)) o.bad++;
            end
            if (k_evt >= 0 && k == k_evt + 1)
                chk(rst_addr ? "rst_mid_outputs" : "abort_outputs", ovec, RST_VEC);
            @(posedge h_clk);
            #1;
            k++;
        end
        if (k_end < 0) chk("timeout", 1, 0);
        start_in = 1'b0; abort_in = 1'b0; h_rst = 1'b0; tick_in = 1'b0;
        e = exp_q.pop_front();
        if (e.cmd  >= 0) chk("cmd_ticks", o.cmd, e.cmd);
        if (e.addr >= 0) chk("addr_ticks", o.addr, e.addr);
        if (e.dum  >= 0) chk("dummy_ticks", o.dum, e.dum);
        if (e.dat  >= 0) chk("data_ticks", o.dat, e.dat);
        if (e.lsd  >= 0) chk("load_shift_data", o.lsd, e.lsd);
        if (e.lat  >= 0) chk("latency", o.lat, e.lat);
        chk("rd_push", o.push, e.push);
        chk("wr_pop", o.pop, e.pop);
        chk("load_cmd_addr", o.ldc, e.ldc);
        chk("err", o.err, e.err);
        chk("done", o.done, e.done);
        chk("io_sel", o.bad, e.bad);
    endtask

    initial begin
        int errs, busys;
        h_rst = 1'b1; tick_in = 1'b0; start_in = 1'b0; wr_in = 1'b0;
        lanes_in = 2'b00; addr_4b_in = 1'b0; beats_in = 5'd0; abort_in = 1'b0;
        repeat (3) @(posedge h_clk);
        #1;
        @(negedge h_clk);
        chk("reset_outputs", ovec, RST_VEC);
        @(posedge h_clk); #1;
        h_rst = 1'b0;
        abort_in = 1'b1;
        @(posedge h_clk); #1;
        abort_in = 1'b0;
        @(negedge h_clk);
        chk("abort_idle", ovec, RST_VEC);
        @(posedge h_clk); #1;

        run_xfer(1'b0, 2'b00, 1'b0, 1,  1, -1, 1'b0, -1);   // single read, 24-bit
        run_xfer(1'b0, 2'b10, 1'b1, 4,  1, -1, 1'b0, -1);   // quad read, 32-bit
        run_xfer(1'b1, 2'b01, 1'b0, 2,  1, -1, 1'b0, 20);   // dual write, restart while busy
        run_xfer(1'b0, 2'b10, 1'b1, 4,  1,  2, 1'b0, -1);   // abort in 3rd beat
        run_xfer(1'b0, 2'b00, 1'b0, 1,  4, -1, 1'b0, -1);   // tick every 4th cycle
        run_xfer(1'b0, 2'b00, 1'b0, 1,  1, -1, 1'b1, -1);   // reset mid-ADDR
        run_xfer(1'b0, 2'b10, 1'b0, 0,  1, -1, 1'b0, -1);   // beats 0 -> 1
        run_xfer(1'b1, 2'b10, 1'b0, 20, 1, -1, 1'b0, -1);   // beats 20 -> 16
        run_xfer(1'b1, 2'b00, 1'b1, 1,  3, -1, 1'b0, -1);   // single write, 32-bit

        errs = 0; busys = 0;
        lanes_in = 2'b11; start_in = 1'b1; tick_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge h_clk);
            if (err_out) errs++;
            if (busy_out) busys++;
            @(posedge h_clk); #1;
            start_in = 1'b0;
        end
        chk("bad_lanes_err", errs, 1);
        chk("bad_lanes_busy", busys, 0);
        @(negedge h_clk);
        chk("bad_lanes_idle", ovec, RST_VEC);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
